// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory read bus for prog_loader.
//   master : host / CPU side; drives the image stream and the read request.
//   slave  : the loader; returns in_ready and the read response.
// Signals:
//   in_data/in_valid/in_last  image byte stream from the host
//   in_ready                  loader accepts a byte this cycle
//   lower_bound/upper_bound   inclusive readable address window
//   mem_addr/mem_extra        read start address and extra byte count
//   mem_data/mem_error        registered read response
interface prog_loader_if #(
   parameter int unsigned AW    = 6,
   parameter int unsigned EXTRA = 4
);
   logic [7:0]               in_data;
   logic                     in_valid;
   logic                     in_last;
   logic                     in_ready;
   logic [AW:0]              lower_bound;
   logic [AW:0]              upper_bound;
   logic [AW:0]              mem_addr;
   logic [EXTRA-1:0]         mem_extra;
   logic [(2**EXTRA)*8-1:0]  mem_data;
   logic                     mem_error;

   modport master (
      output in_data, in_valid, in_last, lower_bound, upper_bound, mem_addr, mem_extra,
      input  in_ready, mem_data, mem_error
   );

   modport slave (
      input  in_data, in_valid, in_last, lower_bound, upper_bound, mem_addr, mem_extra,
      output in_ready, mem_data, mem_error
   );
endinterface

// File: rtl/prog_loader.sv
// Loadable program memory for the CPU. Receives a byte image over a valid/ready stream,
// stores it in an internal byte RAM, then releases the CPU from reset and serves
// multi-byte reads with one cycle of latency.
// Ports:
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   start       one-cycle pulse that (re)starts loading an image
//   cpu_reset   active-high CPU reset, low only while a complete image is served
//   loaded      image complete and reads enabled
//   load_error  image was longer than the RAM
//   bus         stream + read port (slave side)
module prog_loader #(
   parameter int unsigned AW    = 6,
   parameter int unsigned EXTRA = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   output logic          cpu_reset,
   output logic          loaded,
   output logic          load_error,
   prog_loader_if.slave  bus
);

   localparam int unsigned Cap   = 2**(AW+1);
   localparam int unsigned Lanes = 2**EXTRA;
   localparam int unsigned Dw    = Lanes*8;
   // Wide enough that mem_addr + mem_extra can never wrap.
   localparam int unsigned Ew    = AW + EXTRA + 2;

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StFail} state_e;

   state_e          state_q;
   logic [AW+1:0]   wptr_q;
   logic [AW+1:0]   len_q;
   logic            in_ready_q;
   logic            cpu_reset_q;
   logic            loaded_q;
   logic            load_error_q;
   logic [Dw-1:0]   rd_data_q, rd_data_d;
   logic            rd_err_q, rd_err_d;
   logic [Ew-1:0]   end_addr;
   logic [7:0]      ram [Cap];
   logic            wptr_full;
   logic            store;

   // wptr reaches Cap exactly when its top bit sets.
   assign wptr_full = wptr_q[AW+1];
   assign store     = reset_n & ~start & (state_q == StLoad) & bus.in_valid & ~wptr_full;

   // RAM is never cleared; only accepted image bytes are written.
   always_ff @(posedge clk) begin
      if (store) begin
         ram[wptr_q[AW:0]] <= bus.in_data;
      end
   end

   always_comb begin
      end_addr = Ew'(bus.mem_addr) + Ew'(bus.mem_extra);
      rd_err_d = (state_q != StRun)
               | (bus.mem_addr < bus.lower_bound)
               | (end_addr > Ew'(bus.upper_bound))
               | (end_addr >= Ew'(len_q))
               | (end_addr >= Ew'(Cap));
      rd_data_d = '0;
      if (!rd_err_d) begin
         for (int unsigned i = 0; i < Lanes; i++) begin
            if (EXTRA'(i) <= bus.mem_extra) begin
               rd_data_d[8*i +: 8] = ram[bus.mem_addr + (AW+1)'(i)];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         in_ready_q   <= 1'b0;
         cpu_reset_q  <= 1'b1;
         loaded_q     <= 1'b0;
         load_error_q <= 1'b0;
         wptr_q       <= '0;
         len_q        <= '0;
         rd_data_q    <= '0;
         rd_err_q     <= 1'b1;
      end else begin
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
         if (start) begin
            // start overrides any handshake in the same cycle.
            state_q      <= StLoad;
            in_ready_q   <= 1'b1;
            cpu_reset_q  <= 1'b1;
            loaded_q     <= 1'b0;
            load_error_q <= 1'b0;
            wptr_q       <= '0;
            len_q        <= '0;
         end else begin
            case (state_q)
               StLoad: begin
                  if (bus.in_valid) begin
                     if (wptr_full) begin
                        // Byte beyond capacity: discard and latch the error.
                        state_q      <= StFail;
                        in_ready_q   <= 1'b0;
                        load_error_q <= 1'b1;
                     end else begin
                        wptr_q <= wptr_q + 1'b1;
                        if (bus.in_last) begin
                           state_q     <= StRun;
                           in_ready_q  <= 1'b0;
                           loaded_q    <= 1'b1;
                           cpu_reset_q <= 1'b0;
                           len_q       <= wptr_q + 1'b1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_data  = rd_data_q;
   assign bus.mem_error = rd_err_q;
   assign cpu_reset     = cpu_reset_q;
   assign loaded        = loaded_q;
   assign load_error    = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader (AW=2 -> 8-byte RAM, EXTRA=3 -> 8 read lanes) with a
// cycle-level behavioural model of the image store and read rules.
module tb_prog_loader;

   localparam int AW    = 2;
   localparam int EXTRA = 3;
   localparam int CAP   = 8;

   localparam int MIdle = 0;
   localparam int MLoad = 1;
   localparam int MRun  = 2;
   localparam int MErr  = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic cpu_reset, loaded, load_error;

   prog_loader_if #(.AW(AW), .EXTRA(EXTRA)) bus ();

   prog_loader #(.AW(AW), .EXTRA(EXTRA)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .cpu_reset  (cpu_reset),
      .loaded     (loaded),
      .load_error (load_error),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_bad = 0;
   int         m_mode = MIdle;
   int         m_wptr = 0;
   int         m_len = 0;
   logic [7:0] m_ram [CAP];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one clock edge: predict from the model, advance it, then compare every output.
   task automatic step();
      int         e;
      logic       ee;
      logic [63:0] ed;
      e  = int'(bus.mem_addr) + int'(bus.mem_extra);
      ee = (m_mode != MRun) || (bus.mem_addr < bus.lower_bound) ||
           (e > int'(bus.upper_bound)) || (e >= m_len) || (e >= CAP);
      ed = '0;
      if (!ee) begin
         for (int i = 0; i <= int'(bus.mem_extra); i++) ed[8*i +: 8] = m_ram[int'(bus.mem_addr) + i];
      end
      if (!reset_n) begin
         m_mode = MIdle; m_wptr = 0; m_len = 0; ee = 1'b1; ed = '0;
      end else if (start) begin
         m_mode = MLoad; m_wptr = 0; m_len = 0;
      end else if (m_mode == MLoad && bus.in_valid) begin
         if (m_wptr == CAP) begin
            m_mode = MErr;
         end else begin
            m_ram[m_wptr] = bus.in_data;
            m_wptr++;
            if (bus.in_last) begin
               m_mode = MRun;
               m_len  = m_wptr;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("in_ready",   64'(bus.in_ready), 64'(m_mode == MLoad));
      chk("cpu_reset",  64'(cpu_reset),    64'(m_mode != MRun));
      chk("loaded",     64'(loaded),       64'(m_mode == MRun));
      chk("load_error", 64'(load_error),   64'(m_mode == MErr));
      chk("mem_error",  64'(bus.mem_error), 64'(ee));
      chk("mem_data",   bus.mem_data,      ed);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit last);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.in_last  = last;
      step();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic rd(input int a, input int x);
      bus.mem_addr  = (AW+1)'(a);
      bus.mem_extra = EXTRA'(x);
      step();
   endtask

   task automatic set_bounds(input int lo, input int hi);
      bus.lower_bound = (AW+1)'(lo);
      bus.upper_bound = (AW+1)'(hi);
   endtask

   task automatic rand_read();
      bus.mem_addr  = (AW+1)'($urandom_range(0, CAP-1));
      bus.mem_extra = EXTRA'($urandom_range(0, 7));
   endtask

   initial begin
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.mem_addr = '0;
      bus.mem_extra = '0;
      set_bounds(0, 7);

      // Reset values.
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;

      // Basic 4-byte image and a full-width read.
      pulse_start();
      send(8'h00, 0); send(8'h61, 0); send(8'h73, 0); send(8'h6D, 1);
      rd(0, 3);
      chk("t1_data", bus.mem_data, 64'h0000_0000_6D73_6100);
      chk("t1_err", 64'(bus.mem_error), 64'd0);

      // Read ending at len is rejected; single last byte is fine.
      rd(3, 1);
      chk("t2_err", 64'(bus.mem_error), 64'd1);
      rd(3, 0);
      chk("t2_data", bus.mem_data, 64'h6D);

      // Bounds window.
      set_bounds(2, 3);
      rd(1, 0); chk("t6_lo", 64'(bus.mem_error), 64'd1);
      rd(2, 1); chk("t6_ok", bus.mem_data, 64'h6D73);
      rd(3, 1); chk("t6_hi", 64'(bus.mem_error), 64'd1);
      set_bounds(0, 7);

      // Gapped valid: only handshaken bytes are stored.
      pulse_start();
      send(8'hAA, 0);
      bus.in_data = 8'h11; step();
      bus.in_data = 8'h22; step();
      send(8'hBB, 1);
      rd(0, 1); chk("t4_data", bus.mem_data, 64'hBBAA);
      rd(1, 1); chk("t4_len", 64'(bus.mem_error), 64'd1);

      // Overflow: 9 bytes without last.
      pulse_start();
      for (int i = 0; i < 9; i++) send(8'($urandom), 0);
      chk("t3_lerr", 64'(load_error), 64'd1);
      rd(0, 0); chk("t3_rd", 64'(bus.mem_error), 64'd1);
      pulse_start();
      chk("t3_clr", 64'(load_error), 64'd0);

      // Exactly CAP bytes with last on the final one is legal.
      for (int i = 0; i < CAP; i++) send(8'($urandom), i == CAP-1);
      chk("cap_ok", 64'(loaded), 64'd1);
      rd(0, 7); rd(4, 3); rd(7, 0); rd(7, 1);

      // Reset in the middle of a load.
      pulse_start();
      send(8'h12, 0); send(8'h34, 0);
      reset_n = 1'b0; step(); reset_n = 1'b1;
      chk("t5_crst", 64'(cpu_reset), 64'd1);
      rd(0, 0); chk("t5_rd", 64'(bus.mem_error), 64'd1);
      pulse_start();
      send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 1);
      rd(0, 3); chk("t5_data", bus.mem_data, 64'hEFBE_ADDE);

      // Random images with gaps, aborts, stray traffic and random reads.
      for (int r = 0; r < 30; r++) begin
         int n;
         n = $urandom_range(1, 10);
         set_bounds($urandom_range(0, 3), $urandom_range(3, 7));
         pulse_start();
         for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 2) == 0) begin
               rand_read();
               bus.in_data = 8'($urandom);
               step();
            end
            if (r % 7 == 3 && i == 1) begin
               // Restart while a byte is offered: the byte must be dropped.
               bus.in_valid = 1'b1;
               bus.in_data  = 8'($urandom);
               start = 1'b1;
               step();
               start = 1'b0;
               bus.in_valid = 1'b0;
            end
            rand_read();
            send(8'($urandom), (i == n-1) && (n <= CAP));
         end
         for (int k = 0; k < 12; k++) begin
            rand_read();
            bus.in_valid = 1'($urandom);
            bus.in_last  = 1'($urandom);
            bus.in_data  = 8'($urandom);
            step();
         end
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
